jk_bank_arbiter: RTL and testbench

//  Shares one bank of WIDTH JK flip-flops between NREQ requesters.

---
 rtl/jk_bank_arbiter.sv | 139 +++++++++++++
 tb/tb_jk_bank_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_arbiter.sv
// Purpose: one bank of WIDTH JK flip-flops shared by NREQ requesters through a round-robin arbiter.
// Latency: request sampled at edge N, bank updated and gnt pulsed at edge N+1.
// Backpressure: requesters hold req until their gnt pulse; at most one command per 2 cycles.
// Optional macro JK_BANK_LOCK_EN adds lock_mask, which freezes selected bits on update.
module jk_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] j_in,
    input  logic [NREQ*WIDTH-1:0] k_in,
`ifdef JK_BANK_LOCK_EN
    input  logic [WIDTH-1:0]      lock_mask,
`endif
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [IDW-1:0]        owner,
    output logic [WIDTH-1:0]      q,
    output logic [WIDTH-1:0]      qb
);

    typedef enum logic {IDLE, APPLY} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   sel_q, sel_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [WIDTH-1:0] j_lat_q, j_lat_d;
    logic [WIDTH-1:0] k_lat_q, k_lat_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;

    logic [NREQ-1:0]  eligible;
    logic             pick_vld;
    logic [IDW-1:0]   pick_idx;
    logic [WIDTH-1:0] pick_j, pick_k;
    logic [WIDTH-1:0] j_eff, k_eff;
    int               scan_idx;

    // The requester granted last cycle sits out one arbitration round.
    assign eligible = req & ~gnt_q;

`ifdef JK_BANK_LOCK_EN
    // Locked bits see a 00 (hold) command regardless of the latched J/K.
    assign j_eff = j_lat_q & ~lock_mask;
    assign k_eff = k_lat_q & ~lock_mask;
`else
    assign j_eff = j_lat_q;
    assign k_eff = k_lat_q;
`endif

    // Round-robin search: first eligible requester at or after rr_ptr, wrapping.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        pick_j   = '0;
        pick_k   = '0;
        scan_idx = 0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = (int'(rr_ptr_q) + i) % NREQ;
            if (!pick_vld && eligible[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = IDW'(scan_idx);
                pick_j   = j_in[scan_idx*WIDTH +: WIDTH];
                pick_k   = k_in[scan_idx*WIDTH +: WIDTH];
            end
        end
    end

    // Sequencer next state: latch a command in IDLE, apply it for one cycle in APPLY.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        j_lat_d  = j_lat_q;
        k_lat_d  = k_lat_q;
        q_d      = q_q;
        gnt_d    = '0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    sel_d   = pick_idx;
                    j_lat_d = pick_j;
                    k_lat_d = pick_k;
                    state_d = APPLY;
                end
            end
            APPLY: begin
                for (int b = 0; b < WIDTH; b++) begin
                    case ({j_eff[b], k_eff[b]})
                        2'b01:   q_d[b] = 1'b0;
                        2'b10:   q_d[b] = 1'b1;
                        2'b11:   q_d[b] = ~q_q[b];
                        default: q_d[b] = q_q[b];
                    endcase
                end
                gnt_d[sel_q] = 1'b1;
                owner_d      = sel_q;
                rr_ptr_d     = (sel_q == IDW'(NREQ - 1)) ? '0 : sel_q + 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset mid-APPLY discards the pending command entirely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            j_lat_q  <= '0;
            k_lat_q  <= '0;
            q_q      <= '0;
            gnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            j_lat_q  <= j_lat_d;
            k_lat_q  <= k_lat_d;
            q_q      <= q_d;
            gnt_q    <= gnt_d;
        end
    end

    assign gnt   = gnt_q;
    assign busy  = (state_q == APPLY);
    assign owner = owner_q;
    assign q     = q_q;
    assign qb    = ~q_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter (NREQ=4, WIDTH=8): directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model; honours JK_BANK_LOCK_EN.
module tb_jk_bank_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] j_in, k_in;
`ifdef JK_BANK_LOCK_EN
    logic [WIDTH-1:0]      lock_mask;
`endif
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic [IDW-1:0]        owner;
    logic [WIDTH-1:0]      q, qb;

    int n_err    = 0;
    int n_checks = 0;

    jk_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .j_in     (j_in),
        .k_in     (k_in),
`ifdef JK_BANK_LOCK_EN
        .lock_mask(lock_mask),
`endif
        .gnt      (gnt),
        .busy     (busy),
        .owner    (owner),
        .q        (q),
        .qb       (qb)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (transaction level) ----------------
    logic [WIDTH-1:0] m_q, m_j, m_k, nx_q, nx_j, nx_k, m_lock;
    logic [NREQ-1:0]  m_gnt, nx_gnt;
    int               m_rr, m_owner, m_sel, nx_rr, nx_owner, nx_sel, m_pick;
    bit               m_pend, nx_pend;
    wire [WIDTH-1:0]  m_qb = ~m_q;

    // Returns the requester served next, or -1 if nobody is eligible.
    function automatic int first_from(input logic [NREQ-1:0] elig, input int start);
        logic [2*NREQ-1:0] dbl;
        dbl = {elig, elig} >> start;
        for (int p = 0; p < NREQ; p++)
            if (dbl[p]) return (start + p) % NREQ;
        return -1;
    endfunction

    always_comb begin
        m_lock = '0;
`ifdef JK_BANK_LOCK_EN
        m_lock = lock_mask;
`endif
        m_pick   = first_from(req & ~m_gnt, m_rr);
        nx_q     = m_q;
        nx_gnt   = '0;
        nx_owner = m_owner;
        nx_rr    = m_rr;
        nx_pend  = 1'b0;
        nx_sel   = m_sel;
        nx_j     = m_j;
        nx_k     = m_k;
        if (m_pend) begin
            nx_q     = ((m_j & ~m_lock) & ~m_q) | (~(m_k & ~m_lock) & m_q);
            nx_gnt   = NREQ'(1) << m_sel;
            nx_owner = m_sel;
            nx_rr    = (m_sel + 1) % NREQ;
        end else if (m_pick >= 0) begin
            nx_pend = 1'b1;
            nx_sel  = m_pick;
            nx_j    = j_in[m_pick*WIDTH +: WIDTH];
            nx_k    = k_in[m_pick*WIDTH +: WIDTH];
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q <= '0; m_gnt <= '0; m_owner <= 0; m_rr <= 0;
            m_pend <= 1'b0; m_sel <= 0; m_j <= '0; m_k <= '0;
        end else begin
            m_q <= nx_q; m_gnt <= nx_gnt; m_owner <= nx_owner; m_rr <= nx_rr;
            m_pend <= nx_pend; m_sel <= nx_sel; m_j <= nx_j; m_k <= nx_k;
        end
    end

    // Cycle-by-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        check("cyc_q",     32'(q),     32'(m_q));
        check("cyc_qb",    32'(qb),    32'(m_qb));
        check("cyc_gnt",   32'(gnt),   32'(m_gnt));
        check("cyc_busy",  32'(busy),  32'(m_pend));
        check("cyc_owner", 32'(owner), m_owner);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_cmd(input int i, input logic [WIDTH-1:0] j, input logic [WIDTH-1:0] k);
        j_in[i*WIDTH +: WIDTH] = j;
        k_in[i*WIDTH +: WIDTH] = k;
    endtask

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic do_cmd(input int i, input logic [WIDTH-1:0] j, input logic [WIDTH-1:0] k,
                          input logic [WIDTH-1:0] exp_q);
        set_cmd(i, j, k);
        req[i] = 1'b1;
        tick();
        check("cmd_busy", 32'(busy), 32'd1);
        check("cmd_nognt", 32'(gnt), 32'd0);
        set_cmd(i, WIDTH'($urandom), WIDTH'($urandom));
        tick();
        check("cmd_q", 32'(q), 32'(exp_q));
        check("cmd_model_q", 32'(m_q), 32'(exp_q));
        check("cmd_gnt", 32'(gnt), 32'(onehot(i)));
        check("cmd_owner", 32'(owner), i);
        check("cmd_idle", 32'(busy), 32'd0);
        req[i] = 1'b0;
        set_cmd(i, '0, '0);
        tick();
        check("cmd_gnt_pulse", 32'(gnt), 32'd0);
    endtask

    task automatic rr_round(input int start);
        int e;
        j_in = '0;
        k_in = '0;
        req  = '1;
        for (int n = 0; n < NREQ; n++) begin
            e = (start + n) % NREQ;
            tick();
            check("rr_busy", 32'(busy), 32'd1);
            check("rr_nognt", 32'(gnt), 32'd0);
            tick();
            check("rr_gnt", 32'(gnt), 32'(onehot(e)));
            check("rr_model_gnt", 32'(m_gnt), 32'(onehot(e)));
            req[e] = 1'b0;
        end
        tick();
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        j_in = '0;
        k_in = '0;
`ifdef JK_BANK_LOCK_EN
        lock_mask = '0;
`endif
        repeat (3) tick();
        rst = 1'b0;
        check("rst_q", 32'(q), 32'h00);
        check("rst_qb", 32'(qb), 32'hFF);
        check("rst_busy", 32'(busy), 32'd0);

        // Single set command, then JK toggle/clear/hold chain.
        do_cmd(0, 8'h0F, 8'h00, 8'h0F);
        do_cmd(1, 8'hFF, 8'hFF, 8'hF0);
        do_cmd(2, 8'h00, 8'h30, 8'hC0);
        do_cmd(3, 8'h00, 8'h00, 8'hC0);

        // All requesting: round-robin from pointer 0, then from pointer 2.
        rr_round(0);
        do_cmd(1, 8'h00, 8'h00, 8'hC0);
        rr_round(2);
        check("owner_before_rst", 32'(owner), 32'd1);

        // Reset in the APPLY cycle discards the command; it is retried afterwards.
        set_cmd(0, 8'hFF, 8'h00);
        req[0] = 1'b1;
        tick();
        check("r5_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("r5_q", 32'(q), 32'h00);
        check("r5_qb", 32'(qb), 32'hFF);
        check("r5_gnt", 32'(gnt), 32'd0);
        check("r5_busy0", 32'(busy), 32'd0);
        check("r5_owner", 32'(owner), 32'd0);
        tick();
        check("r5_hold_q", 32'(q), 32'h00);
        check("r5_hold_gnt", 32'(gnt), 32'd0);
        rst = 1'b0;
        tick();
        check("r5_retry_busy", 32'(busy), 32'd1);
        tick();
        check("r5_retry_q", 32'(q), 32'hFF);
        check("r5_retry_gnt", 32'(gnt), 32'b0001);
        req = '0;
        tick();

        // Lock mask behaviour (or its absence).
        rst = 1'b1;
        tick();
        rst = 1'b0;
`ifdef JK_BANK_LOCK_EN
        lock_mask = 8'hF0;
        do_cmd(0, 8'hFF, 8'h00, 8'h0F);
        lock_mask = '0;
`else
        do_cmd(0, 8'hFF, 8'h00, 8'hFF);
`endif

        // Randomized traffic with occasional resets and abandoned requests.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && m_gnt[i])
                    req[i] = ($urandom_range(0, 3) == 0);
                else if (req[i])
                    req[i] = ($urandom_range(0, 40) != 0);
                else
                    req[i] = ($urandom_range(0, 2) == 0);
                set_cmd(i, WIDTH'($urandom), WIDTH'($urandom));
            end
`ifdef JK_BANK_LOCK_EN
            lock_mask = WIDTH'($urandom);
`endif
            if (rst)
                rst = 1'b0;
            else if ($urandom_range(0, 250) == 0)
                rst = 1'b1;
        end
        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
